// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: default phase-word geometry and phase detector FSM encoding.
package adpll_pkg;

  localparam int INT_W_DEF  = 8;
  localparam int FRAC_W_DEF = 6;
  localparam int PHASE_W    = INT_W_DEF + FRAC_W_DEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } pe_state_e;

endpackage

// File: rtl/lock_detect.sv
// Lock qualifier: counts consecutive valid phase errors inside +/-LOCK_TH and
// registers LOCK once LOCK_N of them have been seen in a row.
module lock_detect #(
  parameter int W       = 14,
  parameter int LOCK_TH = 8,
  parameter int LOCK_N  = 16
) (
  input  logic         CK,
  input  logic         RB,
  input  logic         CLR,
  input  logic         VLD,
  input  logic [W-1:0] PHE,
  output logic         lock_nxt,
  output logic         LOCK
);

  localparam int             CNT_W   = $clog2(LOCK_N) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_N);
  localparam logic [W-1:0]   TH      = W'(LOCK_TH);
  localparam logic [W-1:0]   MOST_NEG = {1'b1, {(W-1){1'b0}}};

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [W-1:0]     mag;
  logic             in_lock;

  // The most negative code has no positive magnitude, so it is excluded outright.
  always_comb begin
    mag      = PHE[W-1] ? -PHE : PHE;
    in_lock  = (PHE != MOST_NEG) && (mag <= TH);
    cnt_nxt  = cnt;
    if (CLR) begin
      cnt_nxt = '0;
    end else if (VLD) begin
      if (!in_lock)
        cnt_nxt = '0;
      else if (cnt != CNT_MAX)
        cnt_nxt = cnt + CNT_W'(1);
    end
    lock_nxt = (cnt_nxt == CNT_MAX);
  end

  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      cnt  <= '0;
      LOCK <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      LOCK <= lock_nxt;
    end
  end

endmodule

// File: rtl/phase_err_calc.sv
// Reference-domain phase detector: accumulates FCW, compares against the sampled
// variable phase and emits a wrap-safe signed phase error plus a lock flag.
module phase_err_calc
  import adpll_pkg::*;
#(
  parameter int INT_W   = INT_W_DEF,
  parameter int FRAC_W  = FRAC_W_DEF,
  parameter int LOCK_TH = 8,
  parameter int LOCK_N  = 16
) (
  input  logic                    CK,
  input  logic                    RB,
  input  logic                    EB,
  input  logic                    CLR,
  input  logic [INT_W+FRAC_W-1:0] FCW,
  input  logic [INT_W-1:0]        CNT_V,
  input  logic [FRAC_W-1:0]       TDC_F,
  output logic [INT_W+FRAC_W-1:0] PHE,
  output logic                    VLD,
  output logic                    LOCK
);

  localparam int W = INT_W + FRAC_W;

  pe_state_e    state;
  logic [W-1:0] v_in;
  logic [W-1:0] v_s1;
  logic [W-1:0] r_acc;
  logic         s1_vld;
  logic         lock_nxt;

  assign v_in = {CNT_V, {FRAC_W{1'b0}}} - {{INT_W{1'b0}}, TDC_F};

  // Stage 1 captures V and advances R; stage 2 forms R - V one edge later.
  // TRACK/LOCKED follow the lock decision so LOCK is high only in LOCKED.
  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      state  <= IDLE;
      r_acc  <= '0;
      v_s1   <= '0;
      s1_vld <= 1'b0;
      PHE    <= '0;
      VLD    <= 1'b0;
    end else if (CLR) begin
      state  <= IDLE;
      r_acc  <= '0;
      s1_vld <= 1'b0;
      VLD    <= 1'b0;
    end else begin
      VLD <= s1_vld;
      if (s1_vld)
        PHE <= r_acc - v_s1;
      s1_vld <= !EB;
      if (!EB) begin
        v_s1 <= v_in;
        if (state == IDLE)
          r_acc <= v_in;
        else
          r_acc <= r_acc + FCW;
      end
      case (state)
        IDLE:          if (!EB) state <= TRACK;
        TRACK, LOCKED: state <= lock_nxt ? LOCKED : TRACK;
        default:       state <= IDLE;
      endcase
    end
  end

  lock_detect #(
    .W       (W),
    .LOCK_TH (LOCK_TH),
    .LOCK_N  (LOCK_N)
  ) u_lock_detect (
    .CK       (CK),
    .RB       (RB),
    .CLR      (CLR),
    .VLD      (VLD),
    .PHE      (PHE),
    .lock_nxt (lock_nxt),
    .LOCK     (LOCK)
  );

endmodule

// File: tb/tb_phase_err_calc.sv
// Bench for phase_err_calc: directed scenarios plus randomized jitter, checked
// against a sample-level phase model.
module tb_phase_err_calc;
  import adpll_pkg::*;

  localparam int INT_W   = INT_W_DEF;
  localparam int FRAC_W  = FRAC_W_DEF;
  localparam int W       = PHASE_W;
  localparam int LOCK_TH = 8;
  localparam int LOCK_N  = 16;
  localparam int MOD     = 1 << W;

  logic              CK = 1'b0;
  logic              RB = 1'b0;
  logic              EB = 1'b1;
  logic              CLR = 1'b0;
  logic [W-1:0]      FCW = '0;
  logic [INT_W-1:0]  CNT_V = '0;
  logic [FRAC_W-1:0] TDC_F = '0;
  logic [W-1:0]      PHE;
  logic              VLD;
  logic              LOCK;

  int checks = 0;
  int failures = 0;

  // Model: phase error is known at sample time and appears one edge later.
  bit m_seeded, m_pend, m_vld, m_lock;
  int m_r, m_pend_phe, m_phe, m_cnt;
  int true_p;

  phase_err_calc #(
    .INT_W(INT_W), .FRAC_W(FRAC_W), .LOCK_TH(LOCK_TH), .LOCK_N(LOCK_N)
  ) dut (
    .CK(CK), .RB(RB), .EB(EB), .CLR(CLR), .FCW(FCW),
    .CNT_V(CNT_V), .TDC_F(TDC_F), .PHE(PHE), .VLD(VLD), .LOCK(LOCK)
  );

  always #5 CK = ~CK;

  function automatic int wrap(input int x);
    return ((x % MOD) + MOD) % MOD;
  endfunction

  function automatic bit within_lock(input int phe_u);
    int s;
    s = (phe_u >= MOD / 2) ? phe_u - MOD : phe_u;
    return (s != -(MOD / 2)) && (s <= LOCK_TH) && (s >= -LOCK_TH);
  endfunction

  task automatic model_reset();
    m_seeded = 0; m_pend = 0; m_vld = 0; m_lock = 0;
    m_r = 0; m_pend_phe = 0; m_phe = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit eb, input bit clr, input int cnt_v, input int tdc, input int fcw);
    int v;
    if (clr) begin
      m_seeded = 0; m_r = 0; m_pend = 0; m_vld = 0; m_cnt = 0; m_lock = 0;
    end else begin
      if (m_vld) begin
        if (within_lock(m_phe)) m_cnt = (m_cnt < LOCK_N) ? m_cnt + 1 : LOCK_N;
        else                    m_cnt = 0;
        m_lock = (m_cnt == LOCK_N);
      end
      m_vld = m_pend;
      if (m_pend) m_phe = m_pend_phe;
      m_pend = 0;
      if (!eb) begin
        v = wrap(cnt_v * (1 << FRAC_W) - tdc);
        if (!m_seeded) begin
          m_r = v;
          m_seeded = 1;
        end else begin
          m_r = wrap(m_r + fcw);
        end
        m_pend_phe = wrap(m_r - v);
        m_pend = 1;
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    check_val({tag, "_vld"},  32'(VLD),  int'(m_vld));
    check_val({tag, "_phe"},  32'(PHE),  m_phe);
    check_val({tag, "_lock"}, 32'(LOCK), int'(m_lock));
  endtask

  task automatic apply_stimulus(input string tag, input bit eb, input bit clr, input int cnt, input int tdc);
    @(negedge CK);
    EB = eb;
    CLR = clr;
    CNT_V = cnt[INT_W-1:0];
    TDC_F = tdc[FRAC_W-1:0];
    @(posedge CK);
    model_edge(eb, clr, cnt, tdc, int'(FCW));
    #1;
    check_output(tag);
  endtask

  // Advance the true variable phase by FCW and present it as counter + TDC.
  task automatic sample_true(input string tag, input int jitter, input int cnt_bump);
    int meas, cnt, tdc;
    true_p = wrap(true_p + int'(FCW));
    meas = wrap(true_p + jitter);
    cnt = ((meas + (1 << FRAC_W) - 1) >> FRAC_W) & ((1 << INT_W) - 1);
    tdc = wrap(cnt * (1 << FRAC_W) - meas);
    apply_stimulus(tag, 1'b0, 1'b0, cnt + cnt_bump, tdc);
  endtask

  initial begin
    model_reset();
    #1;
    check_val("rst_phe",  32'(PHE),  0);
    check_val("rst_vld",  32'(VLD),  0);
    check_val("rst_lock", 32'(LOCK), 0);
    #2 RB = 1'b1;

    // Seeding from a single sample.
    apply_stimulus("seed", 1'b0, 1'b0, 10, 5);
    apply_stimulus("seed_out", 1'b1, 1'b0, 0, 0);
    check_val("seed_vld1", 32'(VLD), 1);
    check_val("seed_phe0", 32'(PHE), 0);
    apply_stimulus("seed_after", 1'b1, 1'b0, 0, 0);
    check_val("seed_vld0", 32'(VLD), 0);

    // Ideal tracking at 2.5 cycles per sample.
    FCW = 14'd160;
    apply_stimulus("clr1", 1'b1, 1'b1, 0, 0);
    true_p = int'($urandom_range(0, MOD - 1));
    for (int i = 1; i <= 17; i++) sample_true("ideal", 0, 0);
    check_val("ideal_lock_pre", 32'(LOCK), 0);
    sample_true("ideal", 0, 0);
    check_val("ideal_lock_rise", 32'(LOCK), 1);
    for (int i = 0; i < 3; i++) sample_true("ideal", 0, 0);

    // One sample one counter step late, then clean recovery.
    sample_true("inject", 0, 1);
    sample_true("inject_c", 0, 0);
    check_val("inject_phe", 32'(PHE), 16320);
    sample_true("inject_c", 0, 0);
    check_val("inject_unlock", 32'(LOCK), 0);
    for (int i = 3; i <= 17; i++) sample_true("recover", 0, 0);
    check_val("recover_pre", 32'(LOCK), 0);
    sample_true("recover", 0, 0);
    check_val("recover_lock", 32'(LOCK), 1);

    // EB gap with junk on the data inputs.
    for (int i = 0; i < 5; i++)
      apply_stimulus("gap", 1'b1, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 63)));
    sample_true("gap_s", 0, 0);
    apply_stimulus("gap_out", 1'b1, 1'b0, 0, 0);
    check_val("gap_phe", 32'(PHE), 0);
    check_val("gap_vld", 32'(VLD), 1);

    // CLR wins over a simultaneous sample.
    apply_stimulus("clr_prio", 1'b0, 1'b1, 77, 9);
    check_val("clr_prio_vld", 32'(VLD), 0);
    check_val("clr_prio_lock", 32'(LOCK), 0);
    apply_stimulus("clr_idle", 1'b1, 1'b0, 0, 0);
    check_val("clr_idle_vld", 32'(VLD), 0);
    sample_true("clr_seed", 0, 0);
    apply_stimulus("clr_seed_out", 1'b1, 1'b0, 0, 0);
    check_val("clr_seed_phe", 32'(PHE), 0);

    // Counter wrap 252,254,0,2,4 while locked.
    FCW = 14'd128;
    apply_stimulus("clr_wrap", 1'b1, 1'b1, 0, 0);
    true_p = 212 * 64;
    for (int i = 0; i < 25; i++) sample_true("wrap", 0, 0);
    apply_stimulus("wrap_out", 1'b1, 1'b0, 0, 0);
    check_val("wrap_phe", 32'(PHE), 0);
    check_val("wrap_lock", 32'(LOCK), 1);

    // Randomized jitter, gaps, FCW changes and occasional clears.
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 39));
      if (r == 0) begin
        FCW = 14'($urandom_range(0, MOD - 1));
      end
      if (r < 4) begin
        apply_stimulus("rnd_gap", 1'b1, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 63)));
      end else if (r == 4) begin
        apply_stimulus("rnd_clr", 1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(0, 255)), 0);
      end else if (r < 8) begin
        sample_true("rnd_big", int'($urandom_range(0, 600)) - 300, 0);
      end else begin
        sample_true("rnd", int'($urandom_range(0, 20)) - 10, 0);
      end
    end

    // Asynchronous reset while locked and streaming.
    FCW = 14'd160;
    apply_stimulus("clr_rm", 1'b1, 1'b1, 0, 0);
    for (int i = 0; i < 20; i++) sample_true("rm_lock", 0, 0);
    check_val("rm_locked", 32'(LOCK), 1);
    #1 RB = 1'b0;
    #1;
    model_reset();
    check_val("rm_phe",  32'(PHE),  0);
    check_val("rm_vld",  32'(VLD),  0);
    check_val("rm_lock", 32'(LOCK), 0);
    #1 RB = 1'b1;
    sample_true("rm_seed", 0, 0);
    apply_stimulus("rm_out", 1'b1, 1'b0, 0, 0);
    check_val("rm_seed_vld", 32'(VLD), 1);
    check_val("rm_seed_phe", 32'(PHE), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_err_calc.md
# phase_err_calc

Reference-clock-domain phase detector for the ADPLL. It consumes the variable-phase counter value and the TDC fractional correction, both captured by the enable flip-flop bank (EB-gated). It accumulates the reference phase from FCW and produces a signed, wrap-safe phase error for the loop filter. It also provides a lock indicator.

## Interface
- INT_W, 8: integer bits of variable-phase counter (wraps mod 2^INT_W)
- FRAC_W, 6: fractional bits (FCW and TDC_F)
- LOCK_TH, 8: max |PHE| counted as "in lock" (LSB = 2^-FRAC_W cycle)
- LOCK_N, 16: consecutive in-lock samples required to assert LOCK
- CK  in  1  reference clock, rising edge
- RB  in  1  asynchronous, active-low reset
- EB  in  1  active-low sample enable; CK edge with EB=0 takes one sample
- CLR  in  1  synchronous clear to IDLE, active-high
- FCW  in  INT_W+FRAC_W  frequency control word, unsigned
- CNT_V  in  INT_W  sampled variable-phase counter
- TDC_F  in  FRAC_W  TDC fractional correction, unsigned
- PHE  out  INT_W+FRAC_W  phase error, two's complement
- VLD  out  1  PHE valid strobe, one cycle per sample
- LOCK  out  1  lock indicator

## Operation
- W = INT_W+FRAC_W. All phase arithmetic is modulo 2^W. The modular difference read as signed W-bit handles counter wrap with no special case.
- Variable phase: V = {CNT_V, FRAC_W'b0} - TDC_F (mod 2^W).
- Reference accumulator R, W bits.
- Sample rule: each CK edge with EB=0 is one sample. The sample registers V into stage 1 and updates R as the state requires.
- Stage 2: PHE <= R - V (mod 2^W), VLD <= 1. On edges without a stage-1 sample, VLD <= 0 and PHE holds.
- FSM states: IDLE, TRACK, LOCKED.
- IDLE: the first sample seeds R <= V. This forces the first PHE to 0. VLD is asserted for that sample. Next state is TRACK.
- TRACK/LOCKED: each sample does R <= R + FCW and then computes PHE.
- Lock counter (log2(LOCK_N)+1 bits) is evaluated on every VLD.
  - If |PHE| <= LOCK_TH, increment, saturating at LOCK_N. Otherwise clear to 0.
  - -2^(W-1) is never in lock.
- TRACK -> LOCKED when the counter reaches LOCK_N. LOCK=1 in LOCKED only.
- LOCKED -> TRACK on any VLD with |PHE| > LOCK_TH. The counter clears.
- CLR=1 returns to IDLE and clears R, the counter, VLD, and LOCK. PHE holds its last value.
- CLR has priority over a simultaneous EB=0 sample; that sample is discarded.
- EB=1: R, the FSM, and the counter hold.
- FCW changes take effect on the next sample. No retiming is needed.

## Timing
- Reset (RB=0, asynchronous): PHE=0, VLD=0, LOCK=0, R=0, counter=0, state=IDLE. Outputs go low immediately, including in the middle of a pipeline; any in-flight sample is lost.
- Latency: sample at edge n -> PHE/VLD registered at edge n+1. VLD is high for exactly one cycle per sample.
- Back-to-back samples (EB held low) give VLD high continuously at a throughput of 1/cycle.
- LOCK updates at the edge after the deciding VLD (edge n+2 relative to the sample).
- The first sample after reset or CLR always gives PHE=0 and counts toward lock.

## Structure
- Shared package adpll_pkg holds:
  - INT_W/FRAC_W defaults
  - phase-word width constant
  - FSM state encoding (IDLE=2'd0, TRACK=2'd1, LOCKED=2'd2)
- One sub-module, lock_detect, contains the |PHE| compare, the saturating counter, and the LOCK register. It is driven by PHE/VLD/CLR.
- The remainder stays in phase_err_calc: V computation, accumulator, pipeline registers, and FSM.

## Test plan
- **Reset mid-run:** in LOCKED with EB=0 streaming, pulse RB low between edges -> PHE=0, VLD=0, LOCK=0 without a clock. After release, the first sample yields PHE=0.
- **Seeding:** after reset, single sample CNT_V=10, TDC_F=5 -> one edge later VLD=1, PHE=0. The edge after that has VLD=0.
- **Ideal tracking and lock:**
  - Stimulus: FCW=160 (2.5 cycles) with CNT_V/TDC_F consistent with +2.5 per sample, EB=0 continuously.
  - Required: PHE=0 every cycle, and LOCK rises on the edge after the 16th VLD.
- **Wrap:** FCW=128 with CNT_V sequence 252,254,0,2,4 -> PHE=0 throughout, and LOCK is unaffected across 254->0.
- **Error injection:**
  - Stimulus: in LOCKED, one sample with CNT_V one count higher than expected.
  - Required: PHE=-64 (0x3FC0), then LOCK=0 one edge later, then LOCK re-asserts after 16 further clean samples.
- **EB gaps and CLR priority:**
  - EB=1 for 5 cycles between samples -> VLD=0 and R held. The next sample shows PHE=0.
  - CLR=1 together with EB=0 -> state IDLE, no VLD, and the following sample seeds with PHE=0.
